// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the master: it consumes the stream and drives the memory writes.
interface instr_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (input s_data, s_valid, output s_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (output s_data, s_valid, input s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_loader.sv
// Streams a length/payload/checksum image into instruction memory as packed
// little-endian words, and holds the CPU in reset until a load succeeds.
module instr_loader #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  instr_loader_if.master bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code
);
  localparam int CNT_W = $clog2(MEM_BYTES + 1);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      len;
  logic [31:0]      wbuf;
  logic [7:0]       sum;

  logic        xfer;
  logic [31:0] len_nxt;
  logic [31:0] word;
  logic        last;

  assign xfer    = bus.s_valid & bus.s_ready;
  assign len_nxt = {bus.s_data, len[31:8]};
  assign word    = wbuf | (32'(bus.s_data) << {cnt[1:0], 3'b000});
  assign last    = (32'(cnt) + 32'd1) == len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      len           <= '0;
      wbuf          <= '0;
      sum           <= '0;
      bus.s_ready   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state       <= LEN;
            cnt         <= '0;
            len         <= '0;
            wbuf        <= '0;
            sum         <= '0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            cpu_hold    <= 1'b1;
          end
        end
        LEN: begin
          if (xfer) begin
            len <= len_nxt;
            cnt <= cnt + 1'b1;
            if (cnt[1:0] == 2'd3) begin
              cnt <= '0;
              if (len_nxt > 32'(MEM_BYTES)) begin
                state       <= ERR;
                bus.s_ready <= 1'b0;
                busy        <= 1'b0;
                err         <= 1'b1;
                err_code    <= 2'd1;
              end else if (len_nxt == 32'd0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (xfer) begin
            sum <= sum + bus.s_data;
            cnt <= cnt + 1'b1;
            // Flush on a full word or on the tail byte; upper lanes are already zero.
            if (cnt[1:0] == 2'd3 || last) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= ADDR_W'({cnt[CNT_W-1:2], 2'b00});
              bus.mem_wdata <= word;
              wbuf          <= '0;
            end else begin
              wbuf <= word;
            end
            if (last) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            if (bus.s_data == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= 2'd2;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Directed-vector bench for instr_loader: normal, partial, oversize,
// bad-checksum, zero-length, gapped and mid-load reset scenarios.
module tb_instr_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cpu_hold, busy, done, err;
  logic [1:0] err_code;
  int         checks = 0;
  int         errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instr_loader_if #(.ADDR_W(32)) bus ();

  instr_loader #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end

  // {busy, done, err, err_code, cpu_hold, s_ready}
  function automatic logic [6:0] status();
    return {busy, done, err, err_code, cpu_hold, bus.s_ready};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: s_ready=%b required 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int gap, input bit rnd);
    foreach (q[i]) send_byte(q[i], rnd ? int'($urandom_range(0, 2)) : gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (status() !== 7'b0000010) begin
      errors++; $display("FAIL reset_status: got %b required %b", status(), 7'b0000010);
    end
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'd0) begin
      errors++; $display("FAIL reset_mem: we=%b addr=%h data=%h required 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic run_basic(input string name, input logic [7:0] csum, input bit rnd);
    logic [31:0] ea[2] = '{32'h0, 32'h4};
    logic [31:0] ed[2] = '{32'h06010113, 32'h80000537};
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    checks++;
    if (status() !== 7'b1000011) begin
      errors++; $display("FAIL %s busy_status: got %b required %b", name, status(), 7'b1000011);
    end
    send_stream('{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h01, 8'h06,
                  8'h37, 8'h05, 8'h00, 8'h80, csum}, 0, rnd);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++; $display("FAIL %s write_count: got %0d required 2", name, wr_addr_q.size());
    end else
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
          errors++; $display("FAIL %s write%0d: got %h@%h required %h@%h", name, i, wr_data_q[i], wr_addr_q[i], ed[i], ea[i]);
        end
      end
  endtask

  task automatic test_basic();
    run_basic("basic", 8'hD7, 1'b0);
    checks++;
    if (status() !== 7'b0100000) begin
      errors++; $display("FAIL basic_done: got %b required %b", status(), 7'b0100000);
    end
  endtask

  task automatic test_partial();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_stream('{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFC}, 0, 1'b0);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++; $display("FAIL partial_count: got %0d required 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'hDDCCBBAA) begin
        errors++; $display("FAIL partial_w0: got %h@%h required DDCCBBAA@0", wr_data_q[0], wr_addr_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h000000EE) begin
        errors++; $display("FAIL partial_w1: got %h@%h required 000000EE@4", wr_data_q[1], wr_addr_q[1]);
      end
    end
    checks++;
    if (status() !== 7'b0100000) begin
      errors++; $display("FAIL partial_done: got %b required %b", status(), 7'b0100000);
    end
  endtask

  task automatic test_oversize();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_stream('{8'h01, 8'h01, 8'h00, 8'h00}, 0, 1'b0);
    checks++;
    if (status() !== 7'b0010110) begin
      errors++; $display("FAIL oversize_status: got %b required %b", status(), 7'b0010110);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 0 || bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL oversize_quiet: writes=%0d s_ready=%b required 0 0", wr_addr_q.size(), bus.s_ready);
    end
  endtask

  task automatic test_bad_csum();
    run_basic("badcsum", 8'hD8, 1'b0);
    checks++;
    if (status() !== 7'b0011010) begin
      errors++; $display("FAIL badcsum_status: got %b required %b", status(), 7'b0011010);
    end
    run_basic("recover", 8'hD7, 1'b0);
    checks++;
    if (status() !== 7'b0100000) begin
      errors++; $display("FAIL recover_done: got %b required %b", status(), 7'b0100000);
    end
  endtask

  task automatic test_gaps();
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_stream('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 0 || status() !== 7'b0100000) begin
      errors++; $display("FAIL zero_len: writes=%0d status=%b required 0 %b", wr_addr_q.size(), status(), 7'b0100000);
    end
    run_basic("gapped", 8'hD7, 1'b1);
    checks++;
    if (status() !== 7'b0100000) begin
      errors++; $display("FAIL gapped_done: got %b required %b", status(), 7'b0100000);
    end
  endtask

  task automatic test_reset_mid();
    int rdy = 0;
    pulse_start();
    send_stream('{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h01}, 0, 1'b0);
    wr_addr_q.delete(); wr_data_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (status() !== 7'b0000010 || {bus.mem_addr, bus.mem_wdata} !== 64'd0) begin
      errors++; $display("FAIL midreset_status: got %b addr=%h data=%h required %b 0 0", status(), bus.mem_addr, bus.mem_wdata, 7'b0000010);
    end
    bus.s_data  = 8'h06;
    bus.s_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) rdy++;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (rdy != 0 || wr_addr_q.size() != 0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL midreset_ignore: ready_cycles=%0d writes=%0d cpu_hold=%b required 0 0 1", rdy, wr_addr_q.size(), cpu_hold);
    end
    run_basic("after_reset", 8'hD7, 1'b0);
    checks++;
    if (status() !== 7'b0100000) begin
      errors++; $display("FAIL after_reset_done: got %b required %b", status(), 7'b0100000);
    end
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_oversize();
    test_bad_csum();
    test_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
